// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch (IF) plus the IF/ID pipeline register of the
// pipelined RV32I core. It owns PCF and the next-PC select (PC+4 or the EX
// redirect), drives a handshaked instruction-memory port with at most one
// request in flight, and keeps a one-entry hold buffer for a word that
// arrives while the pipeline is stalled.
//
// Memory handshake: imem_req is a request and imem_ack is its completion.
// Once imem_req is high, imem_req and imem_addr stay stable until the cycle
// in which imem_ack is high; that cycle transfers imem_rdata. An ack in the
// same cycle as the request (zero wait) is legal. imem_ack is ignored
// whenever imem_req is low.
//
// dbg_state_o exposes the fetch FSM state (0=FETCH, 1=DRAIN, 2=HOLD) for
// checkers. It is not needed by the rest of the core.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            FetchBusy,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,  // request outstanding at PCF
        DRAIN = 2'd1,  // redirected while waiting; discard the in-flight word
        HOLD  = 2'd2   // word captured under stall; no request issued
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;

    logic            stall;
    logic            deliver;
    logic [31:0]     dlv_instr;
    logic [XLEN-1:0] dlv_pc;

    assign stall       = StallF | StallD;
    // In DRAIN pcf_q has not been updated yet, so the address stays put.
    assign imem_req    = (state_q != HOLD);
    assign imem_addr   = pcf_q;
    assign FetchBusy   = imem_req & ~imem_ack;
    assign dbg_state_o = state_q;

    // Fetch FSM state, PC and hold/pending registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pcf_q        <= RESET_PC;
            pend_pc_q    <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            pend_pc_q    <= pend_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // Next-state, next-PC and delivery toward IF/ID.
    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        pend_pc_d    = pend_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        deliver      = 1'b0;
        dlv_instr    = NOP_INSTR;
        dlv_pc       = pcf_q;

        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    if (PCSrcE) begin
                        // Word is from the wrong path; restart at the target.
                        pcf_d = PCTargetE;
                    end else if (!stall) begin
                        deliver   = 1'b1;
                        dlv_instr = imem_rdata;
                        dlv_pc    = pcf_q;
                        pcf_d     = pcf_q + PC_STEP;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pcf_q;
                        pcf_d        = pcf_q + PC_STEP;
                        state_d      = HOLD;
                    end
                end else if (PCSrcE) begin
                    // Cannot retract the request; remember where to go.
                    pend_pc_d = PCTargetE;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (PCSrcE) begin
                    pend_pc_d = PCTargetE;
                end
                if (imem_ack) begin
                    pcf_d   = PCSrcE ? PCTargetE : pend_pc_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = FETCH;
                end else if (!stall) begin
                    deliver   = 1'b1;
                    dlv_instr = hold_instr_q;
                    dlv_pc    = hold_pc_q;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // IF/ID register: flush beats stall beats load; no delivery loads a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (deliver) begin
                InstrD   <= dlv_instr;
                PCD      <= dlv_pc;
                PCPlus4D <= dlv_pc + PC_STEP;
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A behavioural memory answers imem_req
// combinationally while ack_en is high. Each fetch that should reach decode
// pushes {instr, pc} onto exp_q; a monitor pops one entry for every newly
// loaded valid IF/ID value and compares InstrD, PCD and PCPlus4D.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchBusy;
    logic [1:0]  dbg_state;

    logic        ack_en;
    logic        loaded;
    logic [63:0] exp_q[$];
    int          checks;
    int          errors;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchBusy  (FetchBusy),
        .dbg_state_o(dbg_state)
    );

    // Clock and reset-independent memory model.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0000_ABCD;
        return 32'hC000_0000 | a;
    endfunction

    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_q.push_back({mem_word(pc), pc});
    endtask

    // Remember whether the last edge could load IF/ID.
    always @(posedge clk) loaded <= rst & ~StallD & ~FlushD;

    // Monitor: every freshly loaded valid instruction must match the queue head.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && loaded && ValidD) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_instr", InstrD, 32'h0000_0013);
            end else begin
                e = exp_q.pop_front();
                chk("InstrD", InstrD, e[63:32]);
                chk("PCD", PCD, e[31:0]);
                chk("PCPlus4D", PCPlus4D, e[31:0] + 32'd4);
            end
        end
    end

    initial begin
        checks = 0; errors = 0; loaded = 1'b0;
        rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0; ack_en = 1'b0;

        // Reset values.
        @(negedge clk); #1;
        chk("rst_InstrD", InstrD, 32'h0000_0013);
        chk("rst_ValidD", {31'd0, ValidD}, 32'd0);
        chk("rst_PCD", PCD, 32'd0);
        chk("rst_PCPlus4D", PCPlus4D, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Streaming with zero-wait acks.
        @(negedge clk); rst = 1'b1; ack_en = 1'b1; #1;
        chk("stream_addr0", imem_addr, 32'h0); push(32'h0);
        @(negedge clk); #1;
        chk("stream_addr4", imem_addr, 32'h4); push(32'h4);

        // Ack delayed three cycles at PC 8.
        @(negedge clk); ack_en = 1'b0; #1;
        chk("wait_addr", imem_addr, 32'h8);
        chk("wait_busy", {31'd0, FetchBusy}, 32'd1);
        repeat (2) begin
            @(negedge clk); #1;
            chk("wait_addr", imem_addr, 32'h8);
            chk("wait_busy", {31'd0, FetchBusy}, 32'd1);
            chk("wait_bubble_valid", {31'd0, ValidD}, 32'd0);
            chk("wait_bubble_instr", InstrD, 32'h0000_0013);
        end
        @(negedge clk); ack_en = 1'b1; #1;
        chk("wait_ack_addr", imem_addr, 32'h8);
        chk("wait_ack_busy", {31'd0, FetchBusy}, 32'd0);
        push(32'h8);

        // Redirect to 0x40 while waiting on 0xC.
        @(negedge clk); ack_en = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h40; #1;
        chk("drain_addr0", imem_addr, 32'hC);
        @(negedge clk); PCSrcE = 1'b0; #1;
        chk("drain_addr1", imem_addr, 32'hC);
        chk("drain_busy", {31'd0, FetchBusy}, 32'd1);
        @(negedge clk); ack_en = 1'b1; #1;
        chk("drain_addr2", imem_addr, 32'hC);
        @(negedge clk); #1;
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_bubble", InstrD, 32'h0000_0013);
        push(32'h40);

        // Zero-wait redirect to 0x10, then stall on the word there.
        @(negedge clk); PCSrcE = 1'b1; PCTargetE = 32'h10; #1;
        chk("zredir_addr", imem_addr, 32'h44);
        @(negedge clk); PCSrcE = 1'b0; StallF = 1'b1; StallD = 1'b1; #1;
        chk("hold_addr", imem_addr, 32'h10);
        push(32'h10);
        @(negedge clk); #1;
        chk("hold_req0", {31'd0, imem_req}, 32'd0);
        chk("hold_valid", {31'd0, ValidD}, 32'd0);
        @(negedge clk); StallF = 1'b0; StallD = 1'b0; #1;
        chk("hold_req1", {31'd0, imem_req}, 32'd0);
        @(negedge clk); #1;
        chk("after_hold_addr", imem_addr, 32'h14);
        push(32'h14);

        // Flush together with an ack.
        @(negedge clk); FlushD = 1'b1; #1;
        chk("flush_addr", imem_addr, 32'h18);
        @(negedge clk); FlushD = 1'b0; #1;
        chk("flush_instr", InstrD, 32'h0000_0013);
        chk("flush_valid", {31'd0, ValidD}, 32'd0);
        chk("flush_pc_adv", imem_addr, 32'h1C);
        push(32'h1C);

        // Two redirects during one drain: the later target wins, then wrap.
        @(negedge clk); ack_en = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h80; #1;
        chk("latest_addr0", imem_addr, 32'h20);
        @(negedge clk); PCTargetE = 32'hFFFF_FFFC; #1;
        chk("latest_addr1", imem_addr, 32'h20);
        @(negedge clk); PCSrcE = 1'b0; ack_en = 1'b1; #1;
        chk("latest_ack_busy", {31'd0, FetchBusy}, 32'd0);
        @(negedge clk); #1;
        chk("latest_target", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        @(negedge clk); ack_en = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h80; #1;
        chk("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset in the middle of a drain.
        @(negedge clk); PCSrcE = 1'b0; rst = 1'b0; #1;
        chk("arst_instr", InstrD, 32'h0000_0013);
        chk("arst_valid", {31'd0, ValidD}, 32'd0);
        chk("arst_pcd", PCD, 32'd0);
        chk("arst_pcplus4", PCPlus4D, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        @(negedge clk); rst = 1'b1; ack_en = 1'b1; #1;
        chk("post_rst_addr", imem_addr, 32'h0);
        push(32'h0);
        @(negedge clk); ack_en = 1'b0; #1;
        chk("post_rst_addr4", imem_addr, 32'h4);
        @(negedge clk); #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
